// File: rtl/coproc_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : coproc_arbiter
//  Description : Round-robin arbiter that merges the CPU logic-engine and
//                Python service channels onto one downstream service port.
//                Each request becomes one downstream transaction. A
//                saturating counter records the cycles spent in BUSY.
//                Optional watchdog abort is enabled by defining the macro
//                COPROC_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================

module coproc_arbiter #(
    parameter int          TIMEOUT_CYCLES = 64,
    parameter logic [31:0] TIMEOUT_DATA   = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        logic_req,
    input  logic [31:0] logic_addr,
    output logic        logic_ack,
    output logic [31:0] logic_data,
    input  logic        py_req,
    input  logic [31:0] py_code_addr,
    output logic        py_ack,
    output logic [31:0] py_result,
    output logic        svc_req,
    output logic        svc_sel,
    output logic [31:0] svc_addr,
    input  logic        svc_ack,
    input  logic [31:0] svc_data,
    input  logic        clr_err,
    output logic [1:0]  err_timeout,
    output logic        busy,
    output logic [31:0] busy_cycles
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // svc_sel / last-grant encoding
    localparam logic c_SEL_PY = 1'b1;

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_svc_req;
    logic        r_svc_sel;
    logic [31:0] r_svc_addr;
    logic        r_logic_ack;
    logic        r_py_ack;
    logic [31:0] r_logic_data;
    logic [31:0] r_py_result;
    logic [31:0] r_busy_cycles;
    logic        r_last_grant;
    logic [1:0]  r_mask;

    logic [1:0]  w_req_m;
    logic        w_grant_py;
    logic        w_grant;
    logic        w_capture;
    logic        w_abort;
    logic        w_wd_expired;
    logic        w_done;
    logic [31:0] w_ret_data;

    // Requests seen in IDLE; a channel acked last cycle may still hold its
    // request for one cycle, so it is masked out to avoid a double grant.
    assign w_req_m    = {py_req, logic_req} & ~r_mask;
    assign w_grant_py = (&w_req_m) ? ~r_last_grant : w_req_m[1];
    assign w_done     = w_capture | w_abort;

`ifdef COPROC_TIMEOUT_EN
    localparam logic [15:0] c_WD_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] r_wd;
    logic [1:0]  r_err;
    logic [1:0]  w_err_set;

    assign w_wd_expired = (r_wd == c_WD_LAST);
    assign w_ret_data   = w_abort ? TIMEOUT_DATA : svc_data;
    assign w_err_set    = {w_abort & r_svc_sel, w_abort & ~r_svc_sel};
    assign err_timeout  = r_err;

    // Watchdog: restarts on every grant and counts cycles spent in BUSY
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wd <= 16'd0;
        end else if (w_grant) begin
            r_wd <= 16'd0;
        end else if (r_state == ST_BUSY) begin
            r_wd <= r_wd + 16'd1;
        end
    end

    // Sticky abort flags; a new abort on the same edge beats clr_err
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err <= 2'b00;
        end else begin
            r_err <= (clr_err ? 2'b00 : r_err) | w_err_set;
        end
    end
`else
    logic w_unused_cfg;

    assign w_wd_expired = 1'b0;
    assign w_ret_data   = svc_data;
    assign err_timeout  = 2'b00;
    assign w_unused_cfg = ^{clr_err, TIMEOUT_DATA, TIMEOUT_CYCLES};
`endif

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and transaction strobes; downstream ack beats the watchdog
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_capture   = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (|w_req_m) begin
                    w_grant     = 1'b1;
                    w_state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (svc_ack) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_RESP;
                end else if (w_wd_expired) begin
                    w_abort     = 1'b1;
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Grant latching, result capture, ack pulses and the ack mask
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_svc_req    <= 1'b0;
            r_svc_sel    <= 1'b0;
            r_svc_addr   <= 32'd0;
            r_logic_ack  <= 1'b0;
            r_py_ack     <= 1'b0;
            r_logic_data <= 32'd0;
            r_py_result  <= 32'd0;
            r_last_grant <= c_SEL_PY;
            r_mask       <= 2'b00;
        end else begin
            r_logic_ack <= w_done & ~r_svc_sel;
            r_py_ack    <= w_done & r_svc_sel;
            r_mask      <= {r_py_ack, r_logic_ack};
            if (w_grant) begin
                r_svc_req    <= 1'b1;
                r_svc_sel    <= w_grant_py;
                r_svc_addr   <= w_grant_py ? py_code_addr : logic_addr;
                r_last_grant <= w_grant_py;
            end
            if (w_done) begin
                r_svc_req <= 1'b0;
                if (r_svc_sel == c_SEL_PY) begin
                    r_py_result <= w_ret_data;
                end else begin
                    r_logic_data <= w_ret_data;
                end
            end
        end
    end

    // Saturating count of cycles spent in BUSY
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_busy_cycles <= 32'd0;
        end else if ((r_state == ST_BUSY) && (r_busy_cycles != 32'hFFFF_FFFF)) begin
            r_busy_cycles <= r_busy_cycles + 32'd1;
        end
    end

    assign svc_req     = r_svc_req;
    assign svc_sel     = r_svc_sel;
    assign svc_addr    = r_svc_addr;
    assign logic_ack   = r_logic_ack;
    assign py_ack      = r_py_ack;
    assign logic_data  = r_logic_data;
    assign py_result   = r_py_result;
    assign busy        = (r_state != ST_IDLE);
    assign busy_cycles = r_busy_cycles;

endmodule

`default_nettype wire

// File: tb/tb_coproc_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_coproc_arbiter
//  Description : Self-checking bench for coproc_arbiter with a behavioural
//                round-robin reference model and a downstream responder.
//                Timeout scenarios are built when COPROC_TIMEOUT_EN is set.
//  Revision    : 1.0 - initial release
// ============================================================================

module tb_coproc_arbiter;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        logic_req, py_req, svc_ack, clr_err;
    logic [31:0] logic_addr, py_code_addr, svc_data;
    logic        logic_ack, py_ack, svc_req, svc_sel, busy;
    logic [31:0] logic_data, py_result, svc_addr, busy_cycles;
    logic [1:0]  err_timeout;

    int n_checks = 0;
    int n_fail   = 0;

    // results of the last downstream transaction served by run_svc
    logic        h_to, h_sel, h_lack, h_pack, h_req_resp, h_ack_after, h_busy;
    int          h_gwait, h_reqcnt;
    logic [31:0] h_addr, h_addr_end, h_ldata, h_pdata, h_bc;
    logic [1:0]  h_err;

    coproc_arbiter #(
        .TIMEOUT_CYCLES (TO),
        .TIMEOUT_DATA   (32'hFFFF_FFFF)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .logic_req    (logic_req),
        .logic_addr   (logic_addr),
        .logic_ack    (logic_ack),
        .logic_data   (logic_data),
        .py_req       (py_req),
        .py_code_addr (py_code_addr),
        .py_ack       (py_ack),
        .py_result    (py_result),
        .svc_req      (svc_req),
        .svc_sel      (svc_sel),
        .svc_addr     (svc_addr),
        .svc_ack      (svc_ack),
        .svc_data     (svc_data),
        .clr_err      (clr_err),
        .err_timeout  (err_timeout),
        .busy         (busy),
        .busy_cycles  (busy_cycles)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; logic_req = 1'b0; py_req = 1'b0; svc_ack = 1'b0; clr_err = 1'b0;
        logic_addr = 32'd0; py_code_addr = 32'd0; svc_data = 32'd0;
        step(); step();
        rst_n = 1'b1;
    endtask

    // Round-robin rule: a lone requester wins; on a tie the one not granted last wins
    function automatic int rr(input logic l, input logic p, input int lst);
        if (l && p) return (lst == 1) ? 0 : 1;
        return l ? 0 : 1;
    endfunction

    // Downstream responder: waits for a grant, answers w cycles after it, records outputs
    task automatic run_svc(input int w, input logic [31:0] d, input bit scramble);
        h_to = 1'b0; h_gwait = 0; h_err = 2'b00; h_reqcnt = 0;
        do begin
            step(); h_gwait++; h_err |= err_timeout;
        end while (!svc_req && h_gwait < 50);
        if (!svc_req) begin h_to = 1'b1; return; end
        h_sel = svc_sel; h_addr = svc_addr; h_reqcnt = 1;
        for (int i = 1; i <= w; i++) begin
            if (scramble) begin
                logic_req = 1'($urandom); py_req = 1'($urandom);
                logic_addr = $urandom; py_code_addr = $urandom;
            end
            step(); h_err |= err_timeout;
            if (svc_req) h_reqcnt++;
        end
        h_addr_end = svc_addr;
        svc_ack = 1'b1; svc_data = d;
        step();
        svc_ack = 1'b0; svc_data = $urandom;
        h_lack = logic_ack; h_pack = py_ack; h_ldata = logic_data; h_pdata = py_result;
        h_bc = busy_cycles; h_req_resp = svc_req; h_busy = busy; h_err |= err_timeout;
        step();
        h_ack_after = logic_ack | py_ack; h_err |= err_timeout;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (svc_req !== 1'b0) begin n_fail++; $display("FAIL reset_svc_req: got %b want 0", svc_req); end
        n_checks++; if (svc_sel !== 1'b0) begin n_fail++; $display("FAIL reset_svc_sel: got %b want 0", svc_sel); end
        n_checks++; if ({logic_ack, py_ack, busy} !== 3'b000) begin n_fail++; $display("FAIL reset_acks_busy: got %b want 000", {logic_ack, py_ack, busy}); end
        n_checks++; if (svc_addr !== 32'd0) begin n_fail++; $display("FAIL reset_svc_addr: got %h want 0", svc_addr); end
        n_checks++; if ({logic_data, py_result} !== 64'd0) begin n_fail++; $display("FAIL reset_data: got %h %h want 0", logic_data, py_result); end
        n_checks++; if (busy_cycles !== 32'd0) begin n_fail++; $display("FAIL reset_busy_cycles: got %0d want 0", busy_cycles); end
        n_checks++; if (err_timeout !== 2'b00) begin n_fail++; $display("FAIL reset_err: got %b want 00", err_timeout); end
    endtask

    task automatic test_single_logic();
        do_reset();
        logic_req = 1'b1; logic_addr = 32'h40;
        run_svc(3, 32'h1234, 1'b0);
        n_checks++; if (h_to !== 1'b0) begin n_fail++; $display("FAIL single_grant_wait: got timeout want grant"); end
        n_checks++; if (h_gwait !== 1) begin n_fail++; $display("FAIL single_latency: got %0d want 1", h_gwait); end
        n_checks++; if (h_sel !== 1'b0) begin n_fail++; $display("FAIL single_sel: got %b want 0", h_sel); end
        n_checks++; if (h_addr !== 32'h40) begin n_fail++; $display("FAIL single_addr: got %h want 40", h_addr); end
        n_checks++; if ({h_lack, h_pack} !== 2'b10) begin n_fail++; $display("FAIL single_ack: got l=%b p=%b want l=1 p=0", h_lack, h_pack); end
        n_checks++; if (h_ldata !== 32'h1234) begin n_fail++; $display("FAIL single_data: got %h want 1234", h_ldata); end
        n_checks++; if (h_bc !== 32'd4) begin n_fail++; $display("FAIL single_busy_cycles: got %0d want 4", h_bc); end
        n_checks++; if ({h_busy, h_req_resp} !== 2'b10) begin n_fail++; $display("FAIL single_resp_state: got busy=%b req=%b want 1 0", h_busy, h_req_resp); end
        n_checks++; if (h_ack_after !== 1'b0) begin n_fail++; $display("FAIL single_ack_width: got %b want 0", h_ack_after); end
        // requester still high during the cycle after its ack: must not be re-granted
        step();
        n_checks++; if (svc_req !== 1'b0) begin n_fail++; $display("FAIL single_mask: got svc_req %b want 0", svc_req); end
        logic_req = 1'b0;
        step();
        n_checks++; if ({svc_req, busy} !== 2'b00) begin n_fail++; $display("FAIL single_idle: got %b want 00", {svc_req, busy}); end
    endtask

    task automatic test_tie_alternation();
        logic [31:0] d;
        do_reset();
        logic_req = 1'b1; py_req = 1'b1; logic_addr = 32'hA000_0010; py_code_addr = 32'hB000_0020;
        for (int k = 0; k < 4; k++) begin
            d = $urandom;
            run_svc($urandom_range(0, 3), d, 1'b0);
            n_checks++; if (h_to !== 1'b0 || h_gwait !== 1) begin n_fail++; $display("FAIL tie_grant_%0d: got wait %0d to=%b want 1", k, h_gwait, h_to); end
            n_checks++; if (h_sel !== 1'(k % 2)) begin n_fail++; $display("FAIL tie_sel_%0d: got %b want %0d", k, h_sel, k % 2); end
            n_checks++; if (h_addr !== ((k % 2) ? 32'hB000_0020 : 32'hA000_0010)) begin n_fail++; $display("FAIL tie_addr_%0d: got %h", k, h_addr); end
            n_checks++; if ({h_lack, h_pack} !== ((k % 2) ? 2'b01 : 2'b10)) begin n_fail++; $display("FAIL tie_ack_%0d: got l=%b p=%b", k, h_lack, h_pack); end
            n_checks++; if (((k % 2) ? h_pdata : h_ldata) !== d) begin n_fail++; $display("FAIL tie_data_%0d: got %h want %h", k, (k % 2) ? h_pdata : h_ldata, d); end
        end
        logic_req = 1'b0; py_req = 1'b0;
        step(); step();
    endtask

    task automatic test_random();
        int prev, last, pick, gw, w, v;
        logic lr, pr;
        logic [1:0] elig;
        logic [31:0] la, pa, d, exp_l, exp_p, exp_busy;
        do_reset();
        prev = -1; last = 1; exp_l = 32'd0; exp_p = 32'd0; exp_busy = 32'd0;
        for (int r = 0; r < 40; r++) begin
            v = $urandom_range(1, 3);
            lr = v[0]; pr = v[1]; la = $urandom; pa = $urandom; d = $urandom;
            w = $urandom_range(0, 5);
            logic_req = lr; py_req = pr; logic_addr = la; py_code_addr = pa;
            elig = {pr, lr};
            if (prev == 0) elig[0] = 1'b0;
            if (prev == 1) elig[1] = 1'b0;
            if (elig != 2'b00) begin gw = 1; pick = rr(elig[0], elig[1], last); end
            else begin gw = 2; pick = rr(lr, pr, last); end
            last = pick; prev = pick;
            if (pick == 0) exp_l = d; else exp_p = d;
            exp_busy = exp_busy + 32'(w + 1);
            run_svc(w, d, 1'b1);
            n_checks++; if (h_to !== 1'b0 || h_gwait !== gw) begin n_fail++; $display("FAIL rnd_grant_wait r%0d: got %0d to=%b want %0d", r, h_gwait, h_to, gw); end
            n_checks++; if (h_sel !== 1'(pick)) begin n_fail++; $display("FAIL rnd_sel r%0d: got %b want %0d", r, h_sel, pick); end
            n_checks++; if (h_addr !== (pick ? pa : la) || h_addr_end !== h_addr) begin n_fail++; $display("FAIL rnd_addr r%0d: got %h/%h want %h", r, h_addr, h_addr_end, pick ? pa : la); end
            n_checks++; if (h_reqcnt !== w + 1 || h_req_resp !== 1'b0) begin n_fail++; $display("FAIL rnd_req_len r%0d: got %0d resp=%b want %0d", r, h_reqcnt, h_req_resp, w + 1); end
            n_checks++; if ({h_lack, h_pack} !== (pick ? 2'b01 : 2'b10) || h_ack_after !== 1'b0) begin n_fail++; $display("FAIL rnd_ack r%0d: got l=%b p=%b after=%b", r, h_lack, h_pack, h_ack_after); end
            n_checks++; if (h_ldata !== exp_l || h_pdata !== exp_p) begin n_fail++; $display("FAIL rnd_data r%0d: got %h %h want %h %h", r, h_ldata, h_pdata, exp_l, exp_p); end
            n_checks++; if (h_bc !== exp_busy) begin n_fail++; $display("FAIL rnd_busy_cycles r%0d: got %0d want %0d", r, h_bc, exp_busy); end
            n_checks++; if (h_err !== 2'b00) begin n_fail++; $display("FAIL rnd_err r%0d: got %b want 00", r, h_err); end
        end
        logic_req = 1'b0; py_req = 1'b0;
        step(); step();
    endtask

    task automatic test_reset_mid();
        logic any_ack;
        do_reset();
        logic_req = 1'b1; logic_addr = $urandom | 32'h1;
        run_svc(1, $urandom | 32'h1, 1'b0);
        logic_req = 1'b0;
        py_req = 1'b1; py_code_addr = $urandom | 32'h1;
        for (int i = 0; i < 10 && !svc_req; i++) step();
        step(); step();
        n_checks++; if ({svc_req, busy} !== 2'b11) begin n_fail++; $display("FAIL rstmid_in_busy: got %b want 11", {svc_req, busy}); end
        rst_n = 1'b0; py_req = 1'b0;
        step();
        n_checks++; if (svc_req !== 1'b0) begin n_fail++; $display("FAIL rstmid_svc_req: got %b want 0", svc_req); end
        rst_n = 1'b1; svc_ack = 1'b1; svc_data = $urandom;
        step();
        any_ack = logic_ack | py_ack;
        svc_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin step(); any_ack |= logic_ack | py_ack; end
        n_checks++; if (any_ack !== 1'b0) begin n_fail++; $display("FAIL rstmid_no_ack: got %b want 0", any_ack); end
        n_checks++; if ({svc_req, svc_sel, busy} !== 3'b000) begin n_fail++; $display("FAIL rstmid_ctrl: got %b want 000", {svc_req, svc_sel, busy}); end
        n_checks++; if (svc_addr !== 32'd0) begin n_fail++; $display("FAIL rstmid_addr: got %h want 0", svc_addr); end
        n_checks++; if ({logic_data, py_result} !== 64'd0) begin n_fail++; $display("FAIL rstmid_data: got %h %h want 0", logic_data, py_result); end
        n_checks++; if (busy_cycles !== 32'd0 || err_timeout !== 2'b00) begin n_fail++; $display("FAIL rstmid_cnt_err: got %0d %b want 0 00", busy_cycles, err_timeout); end
    endtask

`ifdef COPROC_TIMEOUT_EN
    task automatic test_timeout();
        int cnt;
        logic [31:0] d;
        do_reset();
        py_req = 1'b1; py_code_addr = $urandom;
        for (int i = 0; i < 10 && !svc_req; i++) step();
        cnt = 0;
        for (int i = 0; i < 100 && svc_req; i++) begin cnt++; step(); end
        n_checks++; if (cnt !== TO) begin n_fail++; $display("FAIL to_req_len: got %0d want %0d", cnt, TO); end
        n_checks++; if ({logic_ack, py_ack} !== 2'b01) begin n_fail++; $display("FAIL to_ack: got l=%b p=%b want l=0 p=1", logic_ack, py_ack); end
        n_checks++; if (py_result !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL to_data: got %h want ffffffff", py_result); end
        n_checks++; if (err_timeout !== 2'b10) begin n_fail++; $display("FAIL to_err: got %b want 10", err_timeout); end
        n_checks++; if (busy_cycles !== 32'(TO)) begin n_fail++; $display("FAIL to_busy_cycles: got %0d want %0d", busy_cycles, TO); end
        py_req = 1'b0;
        step();
        n_checks++; if (err_timeout !== 2'b10) begin n_fail++; $display("FAIL to_sticky: got %b want 10", err_timeout); end
        clr_err = 1'b1; step(); clr_err = 1'b0;
        n_checks++; if (err_timeout !== 2'b00) begin n_fail++; $display("FAIL to_clr: got %b want 00", err_timeout); end
        // ack exactly on the watchdog edge: ack wins
        d = $urandom;
        logic_req = 1'b1; logic_addr = $urandom;
        run_svc(TO - 1, d, 1'b0);
        logic_req = 1'b0;
        n_checks++; if (h_lack !== 1'b1 || h_ldata !== d) begin n_fail++; $display("FAIL to_edge_ack: got ack=%b data=%h want 1 %h", h_lack, h_ldata, d); end
        n_checks++; if (h_err !== 2'b00 || h_reqcnt !== TO) begin n_fail++; $display("FAIL to_edge_err: got %b len %0d want 00 %0d", h_err, h_reqcnt, TO); end
        // logic timeout with clr_err held: the new flag wins
        step();
        clr_err = 1'b1; logic_req = 1'b1;
        for (int i = 0; i < 10 && !svc_req; i++) step();
        logic_req = 1'b0;
        for (int i = 0; i < 100 && svc_req; i++) step();
        n_checks++; if (err_timeout !== 2'b01 || logic_ack !== 1'b1) begin n_fail++; $display("FAIL to_set_wins: got err=%b ack=%b want 01 1", err_timeout, logic_ack); end
        clr_err = 1'b0;
        step();
    endtask
`else
    task automatic test_long_wait();
        logic [31:0] d;
        do_reset();
        d = $urandom;
        logic_req = 1'b1; logic_addr = $urandom;
        run_svc(200, d, 1'b0);
        logic_req = 1'b0;
        n_checks++; if (h_to !== 1'b0 || h_reqcnt !== 201) begin n_fail++; $display("FAIL long_req_len: got %0d to=%b want 201", h_reqcnt, h_to); end
        n_checks++; if (h_lack !== 1'b1 || h_ldata !== d) begin n_fail++; $display("FAIL long_ack: got ack=%b data=%h want 1 %h", h_lack, h_ldata, d); end
        n_checks++; if (h_err !== 2'b00) begin n_fail++; $display("FAIL long_err: got %b want 00", h_err); end
        n_checks++; if (h_bc !== 32'd201) begin n_fail++; $display("FAIL long_busy_cycles: got %0d want 201", h_bc); end
        step();
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL sim_bound: simulation did not complete in time");
        $fatal(1, "simulation bound exceeded");
    end

    initial begin
        test_reset();
        test_single_logic();
        test_tie_alternation();
        test_random();
        test_reset_mid();
`ifdef COPROC_TIMEOUT_EN
        test_timeout();
`else
        test_long_wait();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
